t07_wb_arbiter_rr: RTL and testbench
====================================

# t07_wb_arbiter_rr

Parametrised round-robin Wishbone arbiter that lets NUM_M bus managers share one Wishbone path into the decoder/SRAM side. Typical managers: CPU fetch, CPU data port, and an SPI/ESP32 bulk-load engine. It generalises the single-manager arbitration stage to N managers with fair rotation, a bus-hold-per-cycle grant, and an optional stalled-slave timeout.

## Interface
Parameters:
- NUM_M, 3, number of managers (2..8)
- AW, 32, address width
- DW, 32, data width (multiple of 8); SW = DW/8 select width
- TIMEOUT, 255, wait-state limit in cycles before error (used only with T07_WB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m_cyc_i  in  NUM_M  per-manager cycle request
- m_stb_i  in  NUM_M  per-manager strobe
- m_we_i  in  NUM_M  per-manager write enable
- m_adr_i  in  NUM_M*AW  flattened addresses; manager k at [k*AW +: AW]
- m_dat_i  in  NUM_M*DW  flattened write data
- m_sel_i  in  NUM_M*SW  flattened byte selects
- m_ack_o  out  NUM_M  ack, only to the owner
- m_err_o  out  NUM_M  timeout error, only to the owner
- m_dat_o  out  DW  read data broadcast to all managers; valid only with own ack
- s_cyc_o, s_stb_o, s_we_o  out  1  downstream controls
- s_adr_o  out  AW; s_dat_o  out  DW; s_sel_o  out  SW  downstream payload
- s_ack_i  in  1  downstream ack
- s_dat_i  in  DW  downstream read data
- grant_o  out  NUM_M  one-hot current owner (status)
- busy_o  out  1  high while in GRANT

## Operation
- States: IDLE, GRANT.
- IDLE: if any m_cyc_i high, pick the first requester searching from last+1 upward, modulo NUM_M. Register its one-hot grant_o. Register last = winner. Go to GRANT.
- GRANT: downstream outputs are combinationally muxed from the owner: s_cyc_o = owner cyc, s_stb_o = owner stb, plus we/adr/dat/sel.
  - m_ack_o[owner] = s_ack_i; all other acks are 0.
  - m_dat_o = s_dat_i at all times.
- Release: owner m_cyc_i low in GRANT → s_cyc_o/s_stb_o low that same cycle (combinational); next state IDLE; grant_o cleared next edge.
- A manager may run back-to-back stb beats while holding cyc. It keeps the bus; there is no preemption.
- After release there is always exactly one IDLE cycle before the next grant, even if the same manager re-requests.
- Non-owners see ack=0 and err=0. Their requests wait; their inputs are ignored.
- In IDLE: all s_* outputs are 0, grant_o=0, busy_o=0.

## Timing
- Reset: grant_o=0, busy_o=0, s_cyc_o=s_stb_o=s_we_o=0, s_adr_o=s_dat_o=s_sel_o=0, m_ack_o=m_err_o=0; state IDLE; last=NUM_M-1, so manager 0 wins first.
- Reset asserted mid-transaction: the next edge forces the reset state. The in-flight access is abandoned, with no ack and no err to the manager.
- Grant latency: cyc rises at edge t with the arbiter in IDLE → grant_o and s_cyc_o high from edge t+1.
- Ack latency: zero added cycles (s_ack_i → m_ack_o is combinational).
- Fairness: with all NUM_M managers requesting continuously, grant order is 0,1,…,NUM_M-1,0,…
- Simultaneous release and new request in the same cycle: the new request is arbitrated in the following IDLE cycle.

## Configuration
- T07_WB_TIMEOUT_EN defined:
  - A wait counter clears on entering GRANT and on each s_ack_i. It increments each cycle s_stb_o=1 and s_ack_i=0.
  - When the count reaches TIMEOUT: m_err_o[owner] pulses for 1 cycle, s_cyc_o/s_stb_o are forced 0 that cycle, and the state goes to IDLE. last stays at the owner, so others get priority.
  - s_ack_i and timeout in the same cycle: ack wins, no err, counter cleared.
- Undefined: no counter is synthesised, m_err_o is tied 0, and GRANT waits indefinitely for ack.

## Test plan
- Reset then manager 1 cyc/stb, read adr 0x0000_0040, slave acks 2 cycles later with 0xDEAD_BEEF → grant_o=3'b010 at t+1, m_ack_o=3'b010 with m_dat_o=0xDEAD_BEEF, manager 0/2 ack=0.
- All 3 managers hold cyc, each releases after one acked beat → grant sequence 0,1,2,0 with one IDLE cycle between grants.
- Manager 0 writes 0x1234_5678 sel=4'hF to 0x80, 4 back-to-back beats under one cyc → 4 s_ack_i passed through, no grant change, s_we_o=1 throughout.
- Assert rst during manager 2's wait state → next cycle all outputs 0; afterwards manager 0 wins when 0 and 2 both request.
- With T07_WB_TIMEOUT_EN and TIMEOUT=8, slave never acks → m_err_o[owner] pulses at the 8th wait cycle, s_cyc_o drops, and the next requester is granted after one IDLE cycle.
- With T07_WB_TIMEOUT_EN, ack lands exactly on cycle 8 → m_ack_o high, m_err_o stays 0.

Source files
------------

// File: rtl/t07_wb_arbiter_rr_if.sv
// Wishbone bus bundle between NUM_M managers, the arbiter and one downstream slave path.
// slave modport is the arbiter's view; master modport is the managers'/slave-side driver view.
interface t07_wb_arbiter_rr_if #(
  parameter int NUM_M = 3,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int SW = DW / 8;

  logic [NUM_M-1:0]    m_cyc_i;
  logic [NUM_M-1:0]    m_stb_i;
  logic [NUM_M-1:0]    m_we_i;
  logic [NUM_M*AW-1:0] m_adr_i;
  logic [NUM_M*DW-1:0] m_dat_i;
  logic [NUM_M*SW-1:0] m_sel_i;
  logic [NUM_M-1:0]    m_ack_o;
  logic [NUM_M-1:0]    m_err_o;
  logic [DW-1:0]       m_dat_o;

  logic                s_cyc_o;
  logic                s_stb_o;
  logic                s_we_o;
  logic [AW-1:0]       s_adr_o;
  logic [DW-1:0]       s_dat_o;
  logic [SW-1:0]       s_sel_o;
  logic                s_ack_i;
  logic [DW-1:0]       s_dat_i;

  logic [NUM_M-1:0]    grant_o;
  logic                busy_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
           grant_o, busy_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
           grant_o, busy_o
  );
endinterface

// File: rtl/t07_wb_arbiter_rr.sv
// Round-robin Wishbone arbiter, NUM_M managers onto one path; grant 1 cycle after cyc, ack/data combinational.
// Owner holds the bus until it drops cyc; waiters stall. T07_WB_TIMEOUT_EN adds a stalled-slave error abort.
module t07_wb_arbiter_rr #(
  parameter int NUM_M   = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  t07_wb_arbiter_rr_if.slave    bus
);
  localparam int SW = DW / 8;
  localparam int LW = $clog2(NUM_M);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e           state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [LW-1:0]    last_q, last_d;
  int               owner;
  int               cand;
  logic             found;

`ifdef T07_WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]    wait_q, wait_d;
`else
  logic             unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LW'(NUM_M - 1);
`ifdef T07_WB_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef T07_WB_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    owner       = int'(last_q);
    cand        = 0;
    found       = 1'b0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_dat_o = bus.s_dat_i;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.grant_o = grant_q;
    bus.busy_o  = (state_q == GRANT);
`ifdef T07_WB_TIMEOUT_EN
    wait_d      = wait_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef T07_WB_TIMEOUT_EN
        wait_d = '0;
`endif
        // Search starts just past the previous owner so every requester gets a turn.
        for (int i = 1; i <= NUM_M; i++) begin
          cand = (owner + i) % NUM_M;
          if (!found && bus.m_cyc_i[cand]) begin
            found         = 1'b1;
            last_d        = LW'(cand);
            grant_d       = '0;
            grant_d[cand] = 1'b1;
            state_d       = GRANT;
          end
        end
      end
      GRANT: begin
        if (bus.m_cyc_i[owner]) begin
          bus.s_cyc_o        = 1'b1;
          bus.s_stb_o        = bus.m_stb_i[owner];
          bus.s_we_o         = bus.m_we_i[owner];
          bus.s_adr_o        = bus.m_adr_i[owner*AW +: AW];
          bus.s_dat_o        = bus.m_dat_i[owner*DW +: DW];
          bus.s_sel_o        = bus.m_sel_i[owner*SW +: SW];
          bus.m_ack_o[owner] = bus.s_ack_i;
`ifdef T07_WB_TIMEOUT_EN
          if (bus.s_ack_i) begin
            wait_d = '0;
          end else if (bus.m_stb_i[owner]) begin
            // last_q keeps the owner, so the aborted manager goes to the back of the queue.
            if (wait_q == CW'(TIMEOUT - 1)) begin
              bus.m_err_o[owner] = 1'b1;
              bus.s_cyc_o        = 1'b0;
              bus.s_stb_o        = 1'b0;
              state_d            = IDLE;
              grant_d            = '0;
            end else begin
              wait_d = wait_q + 1'b1;
            end
          end
`endif
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_t07_wb_arbiter_rr.sv
// Directed-vector bench for t07_wb_arbiter_rr with three managers.
module tb_t07_wb_arbiter_rr;
`ifdef T07_WB_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  t07_wb_arbiter_rr_if #(.NUM_M(3), .AW(32), .DW(32)) bus ();

  t07_wb_arbiter_rr #(.NUM_M(3), .AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = '0;
  endtask

  task automatic req(input int k, input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel);
    bus.m_cyc_i[k]         = 1'b1;
    bus.m_stb_i[k]         = 1'b1;
    bus.m_we_i[k]          = we;
    bus.m_adr_i[k*32 +: 32] = adr;
    bus.m_dat_i[k*32 +: 32] = dat;
    bus.m_sel_i[k*4 +: 4]   = sel;
  endtask

  task automatic drop(input int k);
    bus.m_cyc_i[k] = 1'b0;
    bus.m_stb_i[k] = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_grant"}, 64'(bus.grant_o), 64'h0);
    check_eq({tag, "_busy"},  64'(bus.busy_o),  64'h0);
    check_eq({tag, "_scyc"},  64'(bus.s_cyc_o), 64'h0);
    check_eq({tag, "_sstb"},  64'(bus.s_stb_o), 64'h0);
    check_eq({tag, "_swe"},   64'(bus.s_we_o),  64'h0);
    check_eq({tag, "_sadr"},  64'(bus.s_adr_o), 64'h0);
    check_eq({tag, "_sdat"},  64'(bus.s_dat_o), 64'h0);
    check_eq({tag, "_ssel"},  64'(bus.s_sel_o), 64'h0);
    check_eq({tag, "_mack"},  64'(bus.m_ack_o), 64'h0);
    check_eq({tag, "_merr"},  64'(bus.m_err_o), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    check_quiet("rst");

    // Single read by manager 1
    rst = 1'b0;
    req(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF);
    #1 check_eq("rd_idle_grant", 64'(bus.grant_o), 64'h0);
    tick();
    check_eq("rd_grant", 64'(bus.grant_o), 64'b010);
    check_eq("rd_busy",  64'(bus.busy_o),  64'h1);
    check_eq("rd_scyc",  64'(bus.s_cyc_o), 64'h1);
    check_eq("rd_sadr",  64'(bus.s_adr_o), 64'h40);
    check_eq("rd_swe",   64'(bus.s_we_o),  64'h0);
    tick();
    tick();
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'hDEAD_BEEF;
    #1;
    check_eq("rd_ack",  64'(bus.m_ack_o), 64'b010);
    check_eq("rd_mdat", 64'(bus.m_dat_o), 64'hDEAD_BEEF);
    tick();
    bus.s_ack_i = 1'b0;
    drop(1);
    #1;
    check_eq("rel_scyc", 64'(bus.s_cyc_o), 64'h0);
    check_eq("rel_busy", 64'(bus.busy_o),  64'h1);
    tick();
    check_eq("rel_idle_busy",  64'(bus.busy_o),  64'h0);
    check_eq("rel_idle_grant", 64'(bus.grant_o), 64'h0);

    // Fairness: all three request, each releases after one acked beat
    do_reset();
    for (int k = 0; k < 3; k++) req(k, 1'b0, 32'(k * 4), 32'h0, 4'hF);
    tick();
    for (int i = 0; i < 4; i++) begin
      int k;
      logic [2:0] oh;
      k  = i % 3;
      oh = 3'b001 << k;
      bus.s_ack_i = 1'b1;
      #1;
      check_eq($sformatf("rr_grant%0d", i), 64'(bus.grant_o), 64'(oh));
      check_eq($sformatf("rr_ack%0d", i),   64'(bus.m_ack_o), 64'(oh));
      check_eq($sformatf("rr_adr%0d", i),   64'(bus.s_adr_o), 64'(k * 4));
      tick();
      bus.s_ack_i = 1'b0;
      drop(k);
      tick();
      check_eq($sformatf("rr_gap%0d", i), 64'(bus.grant_o), 64'h0);
      req(k, 1'b0, 32'(k * 4), 32'h0, 4'hF);
      tick();
    end

    // Burst: manager 0 writes 4 beats while manager 1 waits
    do_reset();
    req(0, 1'b1, 32'h80, 32'h1234_5678, 4'hF);
    tick();
    req(1, 1'b0, 32'h100, 32'h0, 4'h3);
    for (int b = 0; b < 4; b++) begin
      bus.s_ack_i = 1'b1;
      #1;
      check_eq($sformatf("wr_ack%0d", b),   64'(bus.m_ack_o), 64'b001);
      check_eq($sformatf("wr_grant%0d", b), 64'(bus.grant_o), 64'b001);
      check_eq($sformatf("wr_we%0d", b),    64'(bus.s_we_o),  64'h1);
      check_eq($sformatf("wr_dat%0d", b),   64'(bus.s_dat_o), 64'h1234_5678);
      check_eq($sformatf("wr_sel%0d", b),   64'(bus.s_sel_o), 64'hF);
      tick();
    end
    bus.s_ack_i = 1'b0;
    drop(0);
    tick();
    check_eq("wr_gap", 64'(bus.grant_o), 64'h0);
    tick();
    check_eq("wr_next_grant", 64'(bus.grant_o), 64'b010);
    check_eq("wr_next_sel",   64'(bus.s_sel_o), 64'h3);

    // Reset during manager 2's wait state
    do_reset();
    req(2, 1'b0, 32'h200, 32'h0, 4'hF);
    tick();
    check_eq("mid_grant", 64'(bus.grant_o), 64'b100);
    tick();
    rst = 1'b1;
    tick();
    check_quiet("mid_rst");
    rst = 1'b0;
    req(0, 1'b0, 32'h4, 32'h0, 4'hF);
    tick();
    check_eq("mid_after_grant", 64'(bus.grant_o), 64'b001);

`ifdef T07_WB_TIMEOUT_EN
    // Slave never acks: error on the 8th wait cycle, then manager 1 served
    do_reset();
    req(0, 1'b0, 32'h10, 32'h0, 4'hF);
    req(1, 1'b0, 32'h20, 32'h0, 4'hF);
    tick();
    for (int c = 1; c < 8; c++) begin
      check_eq($sformatf("to_noerr%0d", c), 64'(bus.m_err_o), 64'h0);
      check_eq($sformatf("to_cyc%0d", c),   64'(bus.s_cyc_o), 64'h1);
      tick();
    end
    check_eq("to_err",  64'(bus.m_err_o), 64'b001);
    check_eq("to_scyc", 64'(bus.s_cyc_o), 64'h0);
    tick();
    check_eq("to_gap", 64'(bus.grant_o), 64'h0);
    tick();
    check_eq("to_next_grant", 64'(bus.grant_o), 64'b010);

    // Ack on exactly the 8th cycle wins over the timeout
    do_reset();
    req(0, 1'b0, 32'h10, 32'h0, 4'hF);
    tick();
    for (int c = 1; c < 8; c++) tick();
    bus.s_ack_i = 1'b1;
    #1;
    check_eq("to_ack8_ack", 64'(bus.m_ack_o), 64'b001);
    check_eq("to_ack8_err", 64'(bus.m_err_o), 64'h0);
    tick();
    bus.s_ack_i = 1'b0;
    check_eq("to_ack8_hold", 64'(bus.grant_o), 64'b001);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
